// File: rtl/seg7_scan_pkg.sv
// Shared definitions for the multiplexed 7-segment scanner: segment bit
// positions, the hex glyph table and a small width helper.
package seg7_defs;

  // Bit positions inside the 8-bit segment bus {dp,g,f,e,d,c,b,a}.
  typedef enum int {
    SEG_A  = 0,
    SEG_B  = 1,
    SEG_C  = 2,
    SEG_D  = 3,
    SEG_E  = 4,
    SEG_F  = 5,
    SEG_G  = 6,
    SEG_DP = 7
  } seg_bit_e;

  // Active-high glyphs {g,f,e,d,c,b,a}, indexed by the hex value (0..F).
  localparam logic [15:0][6:0] SEG_PATTERNS = {
    7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
    7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
    7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
    7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
  };

  // Counter width for a modulus of n; never narrower than one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg7_scan_if.sv
// Display-data and pin bundle between the display-select mux (master)
// and the scanner (slave).
interface seg7_scan_if #(
  parameter int DIGITS   = 4,
  parameter int BRIGHT_W = 4
);
  logic [4*DIGITS-1:0] di;
  logic [DIGITS-1:0]   dp;
  logic                lz_blank;
  logic [DIGITS-1:0]   blink_en;
  logic [BRIGHT_W-1:0] bright;
  logic [7:0]          seg;
  logic [DIGITS-1:0]   an;
  logic                frame;

  modport master (
    output di, dp, lz_blank, blink_en, bright,
    input  seg, an, frame
  );

  modport slave (
    input  di, dp, lz_blank, blink_en, bright,
    output seg, an, frame
  );
endinterface

// File: rtl/seg7_scan_hex2seg.sv
// Combinational hex nibble to active-high 7-segment glyph decoder.
module hex2seg
  import seg7_defs::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Straight table lookup; polarity is applied by the caller.
  always_comb seg = SEG_PATTERNS[nibble];

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed 7-segment display scanner: per-slot anode sequencing with an
// anti-ghosting guard, frame-latched display data, leading-zero blanking,
// per-digit blink and PWM brightness. All pins are registered.
module seg7_scan
  import seg7_defs::*;
#(
  parameter int DIGITS       = 4,
  parameter int PRESCALE     = 1000,
  parameter int GUARD        = 2,
  parameter int BRIGHT_W     = 4,
  parameter int BLINK_FRAMES = 128,
  parameter bit AN_ACT_LOW   = 1'b1,
  parameter bit SEG_ACT_LOW  = 1'b1
) (
  input logic        clk,
  input logic        reset,
  seg7_scan_if.slave bus
);

  localparam int PCNT_W = width_of(PRESCALE);
  localparam int IDX_W  = width_of(DIGITS);
  localparam int FCNT_W = width_of(BLINK_FRAMES);

  // Inactive pin levels; XOR-ing an active-high value with these applies polarity.
  localparam logic [DIGITS-1:0] AN_OFF  = AN_ACT_LOW  ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam logic [7:0]        SEG_OFF = SEG_ACT_LOW ? 8'hFF : 8'h00;

  // Display data captured once per frame so a digit never mixes old and new values.
  typedef struct packed {
    logic [4*DIGITS-1:0] di;
    logic [DIGITS-1:0]   dp;
    logic [DIGITS-1:0]   blink_en;
    logic                lz_blank;
  } shadow_t;

  logic [PCNT_W-1:0]   pcnt;
  logic [IDX_W-1:0]    idx;
  logic [BRIGHT_W-1:0] pwm_cnt;
  logic [FCNT_W-1:0]   fcnt;
  logic                blink_phase;
  shadow_t             shadow;

  logic                slot_end;
  logic                frame_end;

  logic [DIGITS-1:0]   lz_mask;
  logic                zero_run;
  logic [3:0]          nibble;
  logic                cur_dp;
  logic                cur_hidden;
  logic [6:0]          glyph;
  logic                an_on;
  logic [DIGITS-1:0]   an_raw;
  logic [7:0]          seg_raw;

  logic [DIGITS-1:0]   an_q;
  logic [7:0]          seg_q;
  logic                frame_q;

  assign slot_end  = (pcnt == PCNT_W'(PRESCALE - 1));
  assign frame_end = slot_end && (idx == IDX_W'(DIGITS - 1));

  // Slot prescaler, digit index (wraps DIGITS-1 -> 0) and free-running PWM counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt    <= '0;
      idx     <= '0;
      pwm_cnt <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      pwm_cnt <= pwm_cnt + 1'b1;
      if (slot_end) begin
        pcnt <= '0;
        idx  <= frame_end ? '0 : idx + 1'b1;
      end else begin
        pcnt <= pcnt + 1'b1;
      end
    end
  end

  // Frame-boundary latch of display data, plus blink frame counter and phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the shadow is a few flops rather than a memory, so it is reset to give a defined all-zero first frame.
      shadow      <= '0;
      fcnt        <= '0;
      blink_phase <= 1'b0;
    end else if (frame_end) begin
      shadow <= '{di: bus.di, dp: bus.dp, blink_en: bus.blink_en, lz_blank: bus.lz_blank};
      if (fcnt == FCNT_W'(BLINK_FRAMES - 1)) begin
        fcnt        <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  // Leading-zero mask and selection of the digit currently being scanned.
  always_comb begin
    // NOTE: every variable is given a default first so no path can infer a latch.
    lz_mask    = '0;
    zero_run   = 1'b1;
    nibble     = 4'h0;
    cur_dp     = 1'b0;
    cur_hidden = 1'b0;
    // Walk down from the top digit; digit 0 is never leading-zero blanked.
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_run   = zero_run && (shadow.di[4*i +: 4] == 4'h0) && !shadow.dp[i];
      lz_mask[i] = zero_run && shadow.lz_blank;
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        nibble     = shadow.di[4*i +: 4];
        cur_dp     = shadow.dp[i];
        cur_hidden = lz_mask[i] || (shadow.blink_en[i] && blink_phase);
      end
    end
  end

  hex2seg u_hex2seg (
    .nibble (nibble),
    .seg    (glyph)
  );

  // Active-high anode/segment values: guard window, PWM gate and blanking.
  always_comb begin
    an_raw  = '0;
    seg_raw = '0;
    an_on   = (pcnt >= PCNT_W'(GUARD)) && (pwm_cnt <= bus.bright) && !cur_hidden;
    for (int i = 0; i < DIGITS; i++) begin
      an_raw[i] = an_on && (idx == IDX_W'(i));
    end
    seg_raw[SEG_G:SEG_A] = glyph;
    seg_raw[SEG_DP]      = cur_dp;
  end

  // Output pin registers with polarity applied; reset forces every pin inactive.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an_q    <= AN_OFF;
      seg_q   <= SEG_OFF;
      frame_q <= 1'b0;
    end else begin
      an_q    <= an_raw ^ AN_OFF;
      seg_q   <= seg_raw ^ SEG_OFF;
      frame_q <= frame_end;
    end
  end

  assign bus.an    = an_q;
  assign bus.seg   = seg_q;
  assign bus.frame = frame_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan. A reference model derives the expected pins
// for every clock from elapsed time since reset (slot, digit, frame number)
// and the frame-latched inputs; a separate monitor pops and compares.
module tb_seg7_scan;

  localparam int DIGITS       = 4;
  localparam int PRESCALE     = 24;
  localparam int GUARD        = 2;
  localparam int BRIGHT_W     = 4;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME_CYC    = DIGITS * PRESCALE;
  localparam int PWM_PERIOD   = 1 << BRIGHT_W;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  seg7_scan_if #(.DIGITS(DIGITS), .BRIGHT_W(BRIGHT_W)) bus ();

  seg7_scan #(
    .DIGITS       (DIGITS),
    .PRESCALE     (PRESCALE),
    .GUARD        (GUARD),
    .BRIGHT_W     (BRIGHT_W),
    .BLINK_FRAMES (BLINK_FRAMES),
    .AN_ACT_LOW   (1'b1),
    .SEG_ACT_LOW  (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [7:0] seg;
    logic       seg_valid;
    logic       frame;
    int         e;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Standard active-high hex glyphs {g,f,e,d,c,b,a}.
  function automatic logic [6:0] glyph_of(input logic [3:0] v);
    case (v)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  // Reference model: expected pins after each clock edge, from time since reset.
  initial begin : model
    int         e;
    int         pc, slot, idx, fno, pwm, phase;
    logic       lz, hidden, on;
    logic [15:0] sh_di;
    logic [3:0]  sh_dp, sh_blink;
    logic        sh_lz;
    exp_t        x;
    e = 0; sh_di = '0; sh_dp = '0; sh_blink = '0; sh_lz = 1'b0;
    forever begin
      @(posedge clk);
      if (!reset) begin
        sb.delete();
        e = 0; sh_di = '0; sh_dp = '0; sh_blink = '0; sh_lz = 1'b0;
      end else begin
        pc    = e % PRESCALE;
        slot  = e / PRESCALE;
        idx   = slot % DIGITS;
        fno   = slot / DIGITS;
        pwm   = e % PWM_PERIOD;
        phase = (fno / BLINK_FRAMES) % 2;
        lz = 1'b0;
        if (sh_lz && idx > 0) begin
          lz = 1'b1;
          for (int j = idx; j < DIGITS; j++)
            if (sh_di[4*j +: 4] != 4'h0 || sh_dp[j]) lz = 1'b0;
        end
        hidden      = lz || (sh_blink[idx] && phase == 1);
        on          = !hidden && pc >= GUARD && pwm <= int'(bus.bright);
        x.an        = on ? ~(4'b0001 << idx) : 4'hF;
        x.seg       = ~{sh_dp[idx], glyph_of(sh_di[4*idx +: 4])};
        x.seg_valid = !hidden;
        x.frame     = ((e % FRAME_CYC) == FRAME_CYC - 1);
        x.e         = e;
        sb.push_back(x);
        if ((e + 1) % FRAME_CYC == 0) begin
          sh_di = bus.di; sh_dp = bus.dp; sh_blink = bus.blink_en; sh_lz = bus.lz_blank;
        end
        e++;
      end
    end
  end

  // Monitor: one output word per clock, compared away from the active edge.
  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("reset_an", 32'(bus.an), 32'h0000_000F);
        check("reset_seg", 32'(bus.seg), 32'h0000_00FF);
        check("reset_frame", 32'(bus.frame), 32'h0);
      end else if (sb.size() == 0) begin
        check("scoreboard_empty", 32'(sb.size()), 32'h1);
      end else begin
        x = sb.pop_front();
        check("an", 32'(bus.an), 32'(x.an));
        if (x.seg_valid) check("seg", 32'(bus.seg), 32'(x.seg));
        check("frame", 32'(bus.frame), 32'(x.frame));
        check("an_onehot", 32'($countones(~bus.an) <= 1), 32'h1);
      end
    end
  end

  task automatic wait_frame();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 2 * FRAME_CYC && !seen; i++) begin
      @(negedge clk);
      if (bus.frame === 1'b1) seen = 1'b1;
    end
    check("frame_seen", 32'(seen), 32'h1);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Stimulus.
  initial begin : stim
    bus.di = 16'h1234; bus.dp = 4'h0; bus.lz_blank = 1'b0;
    bus.blink_en = 4'h0; bus.bright = 4'hF;
    cycles(4);
    #2 reset = 1'b1;
    cycles(2 * FRAME_CYC);                 // zero frame, then 1 2 3 4

    bus.di = 16'h0050; bus.lz_blank = 1'b1;  // leading-zero blanking
    cycles(2 * FRAME_CYC);
    bus.dp = 4'b0100;                        // digit 2 becomes "0."
    cycles(2 * FRAME_CYC);

    bus.dp = 4'h0; bus.lz_blank = 1'b0; bus.di = 16'hAAAA;  // tearing
    wait_frame();
    wait_frame();
    cycles(PRESCALE + PRESCALE / 2);
    bus.di = 16'h5555;
    wait_frame();
    cycles(FRAME_CYC);

    bus.bright = 4'h0;  cycles(FRAME_CYC);   // brightness extremes
    bus.bright = 4'h7;  cycles(FRAME_CYC);
    bus.bright = 4'hF;

    wait_frame();                            // reset in the middle of slot 2
    cycles(2 * PRESCALE + 10);
    #2 reset = 1'b0;
    #1;
    check("async_reset_an", 32'(bus.an), 32'h0000_000F);
    check("async_reset_seg", 32'(bus.seg), 32'h0000_00FF);
    check("async_reset_frame", 32'(bus.frame), 32'h0);
    cycles(3);
    #2 reset = 1'b1;
    bus.blink_en = 4'b0001; bus.di = 16'h89AB;  // blink over frames 0..5
    cycles(6 * FRAME_CYC);

    for (int k = 0; k < 25; k++) begin
      bus.di = 16'($urandom);
      if ($urandom_range(0, 1) == 1) bus.di = bus.di >> (4 * $urandom_range(1, 3));
      bus.dp       = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      bus.lz_blank = 1'($urandom);
      bus.blink_en = 4'($urandom);
      bus.bright   = 4'($urandom);
      cycles($urandom_range(20, 200));
    end

    cycles(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not end, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
